pe_param: RTL
=============

# pe_param

Parametrised output-stationary systolic processing element, the next-generation PE tile for the attention array. Each cycle it forwards the activation right and the weight down, multiplies the valid operand pair, and accumulates into a per-tile accumulator. On the tile's `input_done` it publishes the final sum with a one-cycle `calc_done` pulse. Compared with the current PE, it adds:
- configurable data and accumulator widths,
- signed or unsigned arithmetic,
- an optional multiplier pipeline,
- saturation with an overflow flag,
- valid/done forwarding for chaining,
- back-to-back tiles with no dead cycles.

## Interface
- DATA_W, 16, operand width.
- ACC_W, 36, accumulator/sum width; must satisfy ACC_W >= 2*DATA_W.
- PIPE, 1, number of multiplier register stages (0, 1 or 2).
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 0, 1 = clamp the accumulator on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset; takes priority over `en`.
- en  in  1  global enable; when 0, every register holds.
- active_left  in  DATA_W  activation from the left neighbour.
- left_valid  in  1  `active_left` is valid.
- in_weight  in  DATA_W  weight from the upper neighbour.
- top_valid  in  1  `in_weight` is valid.
- input_done  in  1  marks the last operand cycle of the tile.
- active_right  out  DATA_W  registered copy of `active_left`.
- right_valid  out  1  registered copy of `left_valid`.
- out_weight  out  DATA_W  registered copy of `in_weight`.
- bottom_valid  out  1  registered copy of `top_valid`.
- done_right  out  1  registered copy of `input_done`, for the chain.
- sum  out  ACC_W  result of the last completed tile.
- calc_done  out  1  one-cycle pulse: `sum` has just updated.
- overflow  out  1  overflow flag for the tile reported in `sum`.

## Operation
- **Forwarding:** on every enabled edge, `active_right`, `right_valid`, `out_weight`, `bottom_valid` and `done_right` load their inputs. Forwarding is unconditional and has 1-cycle latency.
- **MAC fire condition:** a MAC fires when `left_valid && top_valid`. If only one side is valid, nothing is accumulated.
- **Product width:** the product is 2*DATA_W wide, sign-extended (SIGNED=1) or zero-extended to ACC_W.
- **Multiplier pipeline:** PIPE stages. Each stage carries the product, a fire bit, and a `last` bit.
  - `last` is set by `input_done`; the operand pair in the same cycle as `input_done` belongs to the tile.
  - `input_done` with no fire injects a zero product with `last` set (zero-length tile).
- **Accumulator, non-`last` fire entry:** acc <= acc + product.
- **Accumulator, `last` entry:**
  - sum <= acc + product, after saturate or wrap;
  - overflow <= the tile's sticky overflow OR the overflow of this add;
  - calc_done <= 1;
  - acc <= 0 and the sticky flag is cleared.
- **Non-completion edges:** on any enabled edge with no `last` entry, calc_done <= 0.
- **Overflow detection:** the add is computed at ACC_W+1 bits.
  - Signed: overflow when the sign differs from the two's-complement range.
  - Unsigned: overflow on carry-out.
- **Saturation:**
  - SATURATE=1: clamp to the signed max/min of ACC_W bits (SIGNED=1), or to the unsigned max/0 (SIGNED=0).
  - SATURATE=0: wrap. `overflow` is still reported.
- **FSM (status and debug only; the datapath ordering comes from the pipeline tags):**
  - IDLE: no fire or `input_done` → stay. Fire → ACCUM. `input_done` → DRAIN.
  - ACCUM: `input_done` → DRAIN.
  - DRAIN: exits on the `last` entry → IDLE, or → ACCUM if a fire occurs in that cycle.
- **Back-to-back tiles:** the next tile's operands may arrive in the cycle right after `input_done`. The pipeline is in order, so the new tile's products reach the freshly cleared accumulator.
- **Stall (`en`=0):** all registers freeze, including the pipeline, the FSM, and outputs. A `calc_done` already high stays high through the stall; downstream samples only when `en`=1.

## Timing
- **Reset values:** all outputs are 0, acc=0, pipeline fire/`last` bits are 0, FSM is IDLE. Reset mid-tile discards the partial accumulation and any in-flight products; no `calc_done` is produced for that tile.
- **Forwarding latency:** 1 enabled cycle.
- **Completion latency:** if `input_done` is sampled in cycle T, `calc_done` is high in cycle T+PIPE+1, and `sum`/`overflow` are valid in that same cycle. Both hold until the next completion.
- **Throughput:** one MAC per cycle. Minimum tile length is 0 operand pairs, and completions may occur in consecutive cycles.
- **Stalls:** each cycle with `en`=0 extends every latency by exactly 1.

## Test plan
- **Basic tile (default parameters):** pairs (1,2),(3,4),(5,6),(7,8), with `input_done` on the 4th → `sum`=100 and `calc_done` high for exactly one cycle, 2 cycles after `input_done`. `active_right`/`out_weight` echo 1,3,5,7 / 2,4,6,8 one cycle late.
- **Signed:** (-3,5),(2,-7) → `sum`=-29 (36'hFFFFFFFE3), `overflow`=0. With SIGNED=0, (16'hFFFF,16'hFFFF) → 36'h0FFFE0001.
- **Back-to-back tiles:** (2,3)+done, then next cycle (4,5)+done → `sum`=6 then 20, with `calc_done` pulses in consecutive cycles. `input_done` alone → `sum`=0.
- **Saturation (DATA_W=16, ACC_W=32, SIGNED=1):** three pairs of (-32768,-32768) → SATURATE=1 gives `sum`=32'h7FFFFFFF; SATURATE=0 gives 32'hC0000000. Both give `overflow`=1, and the next clean tile reports `overflow`=0.
- **Stall and reset:**
  - Drop `en` for 3 cycles mid-tile in the basic tile → `sum` is still 100, `calc_done` arrives 3 cycles later, and outputs are frozen during the stall.
  - Assert `rst` after 2 pairs → all outputs are 0 the next cycle. A following tile (1,1)+done gives `sum`=1.
- **Partial valid:** `left_valid`=1, `top_valid`=0 for (9,9) inside a tile of (1,1),(2,2)+done → `sum`=5, while `right_valid`/`bottom_valid` still forward 1/0.

Source files
------------

// File: rtl/pe_param.sv
// Parametrised output-stationary systolic PE: forwards operands right/down,
// multiplies valid pairs through an optional pipeline and accumulates per tile.
module pe_param #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 36,
  parameter int PIPE     = 1,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] active_left,
  input  logic              left_valid,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              top_valid,
  input  logic              input_done,
  output logic [DATA_W-1:0] active_right,
  output logic              right_valid,
  output logic [DATA_W-1:0] out_weight,
  output logic              bottom_valid,
  output logic              done_right,
  output logic [ACC_W-1:0]  sum,
  output logic              calc_done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  logic                fire_in;
  logic [2*DATA_W-1:0] a_x, b_x, prod;
  logic [ACC_W-1:0]    prod_ext;

  always_comb begin
    fire_in = left_valid && top_valid;
    if (SIGNED != 0) begin
      a_x = {{DATA_W{active_left[DATA_W-1]}}, active_left};
      b_x = {{DATA_W{in_weight[DATA_W-1]}}, in_weight};
    end else begin
      a_x = {{DATA_W{1'b0}}, active_left};
      b_x = {{DATA_W{1'b0}}, in_weight};
    end
    prod = a_x * b_x;
    if (!fire_in)
      prod_ext = '0;
    else if (SIGNED != 0)
      prod_ext = ACC_W'($signed(prod));
    else
      prod_ext = ACC_W'(prod);
  end

  // Entry into the accumulator: either straight from the multiplier or from the last stage.
  logic [ACC_W-1:0] m_prod;
  logic             m_fire, m_last;

  generate
    if (PIPE == 0) begin : g_nopipe
      assign m_prod = prod_ext;
      assign m_fire = fire_in;
      assign m_last = input_done;
    end else begin : g_pipe
      logic [PIPE-1:0][ACC_W-1:0] prod_q, prod_d;
      logic [PIPE-1:0]            fire_q, fire_d, last_q, last_d;

      always_comb begin
        prod_d    = prod_q;
        fire_d    = fire_q;
        last_d    = last_q;
        prod_d[0] = prod_ext;
        fire_d[0] = fire_in;
        last_d[0] = input_done;
        for (int i = 1; i < PIPE; i++) begin
          prod_d[i] = prod_q[i-1];
          fire_d[i] = fire_q[i-1];
          last_d[i] = last_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          prod_q <= '0;
          fire_q <= '0;
          last_q <= '0;
        end else if (en) begin
          prod_q <= prod_d;
          fire_q <= fire_d;
          last_q <= last_d;
        end
      end

      assign m_prod = prod_q[PIPE-1];
      assign m_fire = fire_q[PIPE-1];
      assign m_last = last_q[PIPE-1];
    end
  endgenerate

  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, addend, add_res;
  logic             sticky_q, sticky_d, overflow_q, overflow_d, calc_done_q, calc_done_d;
  logic [ACC_W:0]   sum_wide;
  logic             add_ovf;

  // One extra bit exposes signed range overflow or unsigned carry-out.
  always_comb begin
    addend = m_fire ? m_prod : '0;
    if (SIGNED != 0) begin
      sum_wide = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};
      add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    end else begin
      sum_wide = {1'b0, acc_q} + {1'b0, addend};
      add_ovf  = sum_wide[ACC_W];
    end
    add_res = sum_wide[ACC_W-1:0];
    if (add_ovf && (SATURATE != 0)) begin
      if (SIGNED == 0)
        add_res = '1;
      else if (sum_wide[ACC_W])
        add_res = {1'b1, {(ACC_W-1){1'b0}}};
      else
        add_res = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    sum_d       = sum_q;
    overflow_d  = overflow_q;
    calc_done_d = 1'b0;
    if (m_last) begin
      sum_d       = add_res;
      overflow_d  = sticky_q | add_ovf;
      calc_done_d = 1'b1;
      acc_d       = '0;
      sticky_d    = 1'b0;
    end else if (m_fire) begin
      acc_d    = add_res;
      sticky_d = sticky_q | add_ovf;
    end
  end

  logic [DATA_W-1:0] active_right_q, out_weight_q;
  logic              right_valid_q, bottom_valid_q, done_right_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= '0;
      sticky_q       <= 1'b0;
      sum_q          <= '0;
      overflow_q     <= 1'b0;
      calc_done_q    <= 1'b0;
      active_right_q <= '0;
      out_weight_q   <= '0;
      right_valid_q  <= 1'b0;
      bottom_valid_q <= 1'b0;
      done_right_q   <= 1'b0;
    end else if (en) begin
      acc_q          <= acc_d;
      sticky_q       <= sticky_d;
      sum_q          <= sum_d;
      overflow_q     <= overflow_d;
      calc_done_q    <= calc_done_d;
      active_right_q <= active_left;
      out_weight_q   <= in_weight;
      right_valid_q  <= left_valid;
      bottom_valid_q <= top_valid;
      done_right_q   <= input_done;
    end
  end

  assign active_right = active_right_q;
  assign out_weight   = out_weight_q;
  assign right_valid  = right_valid_q;
  assign bottom_valid = bottom_valid_q;
  assign done_right   = done_right_q;
  assign sum          = sum_q;
  assign overflow     = overflow_q;
  assign calc_done    = calc_done_q;

  // Status FSM; the datapath never depends on it, ordering comes from the pipeline tags.
  state_e state_q, state_d;
  logic   tile_busy;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else if (en)
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (input_done) state_d = DRAIN;
               else if (fire_in) state_d = ACCUM;
      ACCUM:   if (input_done) state_d = DRAIN;
      DRAIN:   if (input_done) state_d = DRAIN;
               else if (m_last) state_d = fire_in ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tile_busy = (state_q != IDLE);
  end

endmodule
